// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RV64M divider.
package riscv_core_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [XLEN-1:0] MIN_XLEN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD  = {{(XLEN-31){1'b1}}, {31{1'b0}}};

endpackage

// File: rtl/riscv_core_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module riscv_core_div_step #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_dvd_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_q_bit
);

    logic [W:0] w_trial;
    logic [W:0] w_diff;

    // The shifted remainder can reach 2*divisor-1, so compare at W+1 bits.
    always_comb begin
        w_trial = {i_rem, i_dvd_bit};
        w_diff  = w_trial - {1'b0, i_divisor};
        o_q_bit = (w_trial >= {1'b0, i_divisor});
        o_rem   = o_q_bit ? w_diff[W-1:0] : w_trial[W-1:0];
    end

endmodule

// File: rtl/riscv_core_div_64bit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
module riscv_core_div_64bit
    import riscv_core_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_core_div_valid,
    output logic            o_core_div_ready,
    input  logic [1:0]      i_core_div_op,
    input  logic            i_core_div_word,
    input  logic [XLEN-1:0] i_core_div_op1,
    input  logic [XLEN-1:0] i_core_div_op2,
    output logic            o_core_div_valid,
    input  logic            i_core_div_resp_ready,
    output logic [XLEN-1:0] o_core_div_result
);

    div_state_t      r_state;
    div_op_t         r_op;
    logic            r_word;
    logic            r_sign_q;
    logic            r_sign_r;
    logic [6:0]      r_cnt;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dsr;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_result;
    logic            r_ready;
    logic            r_valid;

    div_op_t         w_op;
    logic            w_signed;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_step_rem;
    logic            w_step_q;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_res;

    // W forms are widened to XLEN up front so one datapath serves both widths.
    always_comb begin
        w_op     = div_op_t'(i_core_div_op);
        w_signed = (w_op == DIV) || (w_op == REM);
        if (i_core_div_word) begin
            w_a = w_signed ? {{32{i_core_div_op1[31]}}, i_core_div_op1[31:0]}
                           : {32'b0, i_core_div_op1[31:0]};
            w_b = w_signed ? {{32{i_core_div_op2[31]}}, i_core_div_op2[31:0]}
                           : {32'b0, i_core_div_op2[31:0]};
        end else begin
            w_a = i_core_div_op1;
            w_b = i_core_div_op2;
        end
        w_a_neg    = w_signed & w_a[XLEN-1];
        w_b_neg    = w_signed & w_b[XLEN-1];
        w_a_abs    = w_a_neg ? (~w_a + 1'b1) : w_a;
        w_b_abs    = w_b_neg ? (~w_b + 1'b1) : w_b;
        w_div_zero = (w_b == '0);
        w_ovf      = w_signed && (w_b == '1) &&
                     (w_a == (i_core_div_word ? MIN_WORD : MIN_XLEN));
    end

    always_comb begin
        w_quo_fix = r_sign_q ? (~r_quo + 1'b1) : r_quo;
        w_rem_fix = r_sign_r ? (~r_rem + 1'b1) : r_rem;
        w_sel     = ((r_op == DIV) || (r_op == DIVU)) ? r_quo : r_rem;
        w_res     = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
    end

    riscv_core_div_step #(
        .W (XLEN)
    ) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_dvd[XLEN-1]),
        .i_divisor (r_dsr),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_q)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_op     <= DIV;
            r_word   <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_core_div_valid && r_ready) begin
                        r_op    <= w_op;
                        r_word  <= i_core_div_word;
                        r_ready <= 1'b0;
                        if (w_div_zero) begin
                            r_quo   <= '1;
                            r_rem   <= w_a;
                            r_state <= DONE;
                        end else if (w_ovf) begin
                            r_quo   <= w_a;
                            r_rem   <= '0;
                            r_state <= DONE;
                        end else begin
                            // W dividends are left-aligned so the MSB feed is always bit XLEN-1.
                            r_dvd    <= i_core_div_word ? {w_a_abs[31:0], 32'b0} : w_a_abs;
                            r_dsr    <= w_b_abs;
                            r_quo    <= '0;
                            r_rem    <= '0;
                            r_sign_q <= w_a_neg ^ w_b_neg;
                            r_sign_r <= w_a_neg;
                            r_cnt    <= i_core_div_word ? 7'd31 : 7'd63;
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[XLEN-2:0], w_step_q};
                    r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
                    if (r_cnt == 7'd0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - 7'd1;
                    end
                end
                FIX: begin
                    r_quo   <= w_quo_fix;
                    r_rem   <= w_rem_fix;
                    r_state <= DONE;
                end
                DONE: begin
                    // First DONE cycle registers the selected result; it is then held until taken.
                    if (!r_valid) begin
                        r_valid  <= 1'b1;
                        r_result <= w_res;
                    end else if (i_core_div_resp_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_core_div_ready  = r_ready;
    assign o_core_div_valid  = r_valid;
    assign o_core_div_result = r_result;

endmodule

// File: tb/tb_riscv_core_div_64bit.sv
// Directed self-checking bench for riscv_core_div_64bit.
module tb_riscv_core_div_64bit;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [1:0]  op;
    logic        word;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        rvalid;
    logic        resp_ready;
    logic [63:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    riscv_core_div_64bit dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_core_div_valid      (valid),
        .o_core_div_ready      (ready),
        .i_core_div_op         (op),
        .i_core_div_word       (word),
        .i_core_div_op1        (op1),
        .i_core_div_op2        (op2),
        .o_core_div_valid      (rvalid),
        .i_core_div_resp_ready (resp_ready),
        .o_core_div_result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        check({tag, "_ready"}, {63'b0, ready}, 64'd1);
        op    = o;
        word  = w;
        op1   = a;
        op2   = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input logic [63:0] exp);
        int n;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (rvalid) begin
                n = i;
                break;
            end
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, result, exp);
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'b0, rvalid}, 64'd0);
        check({tag, "_ready_back"}, {63'b0, ready}, 64'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input int lat, input logic [63:0] exp);
        issue(tag, o, w, a, b);
        wait_result(tag, lat, exp);
        take(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        valid      = 1'b0;
        op         = OP_DIV;
        word       = 1'b0;
        op1        = '0;
        op2        = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  {63'b0, ready},  64'd1);
        check("rst_valid",  {63'b0, rvalid}, 64'd0);
        check("rst_result", result,          64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("divu_100_7",  OP_DIVU, 1'b0, 64'd100, 64'd7, 66, 64'hE);
        run("remu_100_7",  OP_REMU, 1'b0, 64'd100, 64'd7, 66, 64'd2);
        run("div_m7_2",    OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD);
        run("rem_m7_2",    OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFF);
        run("divu_x_0",    OP_DIVU, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run("remu_x_0",    OP_REMU, 1'b0, 64'h1234, 64'd0, 1, 64'h1234);
        run("div_ovf",     OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
            64'h8000_0000_0000_0000);
        run("rem_ovf",     OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
        run("divw_ovf",    OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
            64'hFFFF_FFFF_8000_0000);
        run("divuw",       OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 34, 64'h0000_0000_7FFF_FFFF);
        run("remw_m7_2",   OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 34, 64'hFFFF_FFFF_FFFF_FFFF);
        run("divw_20_m3",  OP_DIV,  1'b1, 64'd20, 64'h0000_0000_FFFF_FFFD, 34, 64'hFFFF_FFFF_FFFF_FFFA);
        run("remuw_x_0",   OP_REMU, 1'b1, 64'hABCD_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 1,
            64'hFFFF_FFFF_8000_0001);
        run("div_max_3",   OP_DIV,  1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 66, 64'h2AAA_AAAA_AAAA_AAAA);
        run("remu_big",    OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 66,
            64'h7FFF_FFFF_FFFF_FFFF);
        run("divu_ones_1", OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66, 64'hFFFF_FFFF_FFFF_FFFF);

        // Back-pressure: result held, ready low, new request ignored.
        issue("bp", OP_DIVU, 1'b0, 64'd100, 64'd7);
        wait_result("bp", 66, 64'hE);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            valid = (c == 3);
            op    = OP_DIV;
            op1   = 64'd1;
            op2   = 64'd0;
            @(posedge clk);
            #1;
            valid = 1'b0;
            check("bp_valid",  {63'b0, rvalid}, 64'd1);
            check("bp_result", result,          64'hE);
            check("bp_ready",  {63'b0, ready},  64'd0);
        end
        take("bp");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_no_queue", {63'b0, rvalid}, 64'd0);
        end

        // Reset in the middle of an iteration.
        issue("rst_mid", OP_DIVU, 1'b0, 64'hFFFF, 64'd3);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_ready", {63'b0, ready},  64'd1);
        check("rstmid_valid", {63'b0, rvalid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) begin
            @(posedge clk);
            #1;
            check("rstmid_no_result", {63'b0, rvalid}, 64'd0);
        end
        run("divu_9_3", OP_DIVU, 1'b0, 64'd9, 64'd3, 66, 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
